// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_send: buffers pushes and runs the ready/busy/done handshake per byte.
// Optional synchronous flush port enabled by defining UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_ready,
  output logic [WIDTH-1:0]       tx_payload,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] payload_q, payload_d;
  logic             flush_w, push, pop;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_payload = payload_q;
  assign tx_ready   = (state_q == SEND);

  // Flush wins over both push and the LOAD pop; a byte loaded during flush is discarded.
  assign push = wr_en && !full && !flush_w;
  assign pop  = (state_q == LOAD) && !empty && !flush_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty && !flush_w) state_d = LOAD;
      LOAD: state_d = pop ? SEND : IDLE;
      SEND: if (tx_busy) state_d = WAIT;
      WAIT: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    payload_d  = pop  ? mem_q[rd_ptr_q]    : payload_q;
    overflow_d = overflow_q | (wr_en && full);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    if (flush_w) begin
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      payload_q  <= payload_d;
    end
  end

  // Storage needs no reset: count/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
